// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - pipeline hazard detection with stall FSM and saturating stall/flush counters
module hazard_detection_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_IsBranch,
  input  logic        PCSrcTaken,
  input  logic [1:0]  ID_EX_MemRead,
  input  logic        ID_EX_RegWrite,
  input  logic [4:0]  ID_EX_WriteReg,
  input  logic [1:0]  EX_MEM_MemRead,
  input  logic [4:0]  EX_MEM_WriteReg,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        controlMuxSignal,
  output logic        IF_ID_Flush,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushCount
);

  typedef enum logic {RUN = 1'b0, STALL1 = 1'b1} state_t;

  state_t      r_state;
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  logic w_match_ex;
  logic w_match_mem;
  logic w_h_lu;
  logic w_h_ba;
  logic w_h_bl;
  logic w_h_bm;
  logic w_stall;
  logic w_flush;

  // Register 0 is hard-wired zero, so a write to it can never create a dependency
  assign w_match_ex  = (ID_EX_WriteReg != 5'd0) &&
                       ((ID_EX_WriteReg == IF_ID_Rs) || (ID_UsesRt && (ID_EX_WriteReg == IF_ID_Rt)));
  assign w_match_mem = (EX_MEM_WriteReg != 5'd0) &&
                       ((EX_MEM_WriteReg == IF_ID_Rs) || (ID_UsesRt && (EX_MEM_WriteReg == IF_ID_Rt)));

  assign w_h_lu = (ID_EX_MemRead != 2'b00) && w_match_ex;
  assign w_h_ba = ID_IsBranch && ID_EX_RegWrite && (ID_EX_MemRead == 2'b00) && w_match_ex;
  assign w_h_bl = ID_IsBranch && w_h_lu;
  assign w_h_bm = ID_IsBranch && (EX_MEM_MemRead != 2'b00) && w_match_mem;

  // STALL1 forces the second bubble of a branch-on-load regardless of the current inputs
  assign w_stall = (r_state == STALL1) || w_h_lu || w_h_ba || w_h_bl || w_h_bm;
  // A stall suppresses the flush; the branch is re-evaluated once the pipeline moves again
  assign w_flush = !w_stall && PCSrcTaken;

  // Pipeline control: everything frozen while in reset, otherwise driven by stall/flush
  always_comb begin
    PCWrite          = 1'b0;
    IF_ID_Write      = 1'b0;
    controlMuxSignal = 1'b0;
    IF_ID_Flush      = 1'b0;
    if (!Reset) begin
      PCWrite          = !w_stall;
      IF_ID_Write      = !w_stall;
      controlMuxSignal = !w_stall;
      IF_ID_Flush      = w_flush;
    end
  end

  // Stall FSM: only a branch on a load in EX needs an extra cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     r_state <= w_h_bl ? STALL1 : RUN;
        STALL1:  r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  // Saturating event counters for stall cycles and issued flushes
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cycles <= 16'd0;
      r_flush_count  <= 16'd0;
    end else begin
      if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (w_flush && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign StallCycles = r_stall_cycles;
  assign FlushCount  = r_flush_count;

endmodule
